// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 16x16 register file: two one-entry writeback buffers drained
// round-robin into registered write outputs. Define WB_FORWARD_EN to add pending-write forwarding.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [ADDR_W-1:0] Req0Reg,
    input  logic [DATA_W-1:0] Req0Data,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [ADDR_W-1:0] Req1Reg,
    input  logic [DATA_W-1:0] Req1Data,
    output logic              RegWre,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
`ifdef WB_FORWARD_EN
    input  logic [ADDR_W-1:0] FwdAddr1,
    input  logic [ADDR_W-1:0] FwdAddr2,
    output logic              FwdHit1,
    output logic              FwdHit2,
    output logic [DATA_W-1:0] FwdData1,
    output logic [DATA_W-1:0] FwdData2,
`endif
    output logic              Busy
);
    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] regAddr;
        logic [DATA_W-1:0] data;
    } wbEntry_t;

    wbEntry_t [1:0]             bufQ, bufNext;
    logic [1:0]                 reqValid, reqReady, fill, drain;
    logic [1:0][ADDR_W-1:0]     reqReg;
    logic [1:0][DATA_W-1:0]     reqData;
    logic                       olderIdx, ageNext, rrPtr;
    logic                       grantVld, grantIdx;

    assign reqValid  = {Req1Valid, Req0Valid};
    assign reqReg    = {Req1Reg, Req0Reg};
    assign reqData   = {Req1Data, Req0Data};
    assign Req0Ready = reqReady[0];
    assign Req1Ready = reqReady[1];
    assign Busy      = bufQ[0].vld | bufQ[1].vld;

    // Grant is a function of buffer state only, so Ready never loops back through Valid.
    always_comb begin
        grantVld = Busy;
        grantIdx = bufQ[1].vld;
        if (bufQ[0].vld && bufQ[1].vld)
            grantIdx = (bufQ[0].regAddr == bufQ[1].regAddr) ? olderIdx : rrPtr;
    end

    for (genvar n = 0; n < 2; n++) begin : g_req
        assign drain[n]    = grantVld & (grantIdx == 1'(n));
        assign reqReady[n] = ~bufQ[n].vld | drain[n];
        assign fill[n]     = reqValid[n] & reqReady[n];
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            bufNext[n] = bufQ[n];
            if (drain[n])
                bufNext[n].vld = 1'b0;
            if (fill[n])
                bufNext[n] = '{vld: 1'b1, regAddr: reqReg[n], data: reqData[n]};
        end
        // A freshly filled buffer is younger than one that stays; a same-edge double fill ranks buffer 0 older.
        ageNext = olderIdx;
        if (fill[0] && fill[1])
            ageNext = 1'b0;
        else if (fill[0])
            ageNext = bufNext[1].vld;
        else if (fill[1])
            ageNext = ~bufNext[0].vld;
        else if (!(bufNext[0].vld && bufNext[1].vld))
            ageNext = bufNext[1].vld & ~bufNext[0].vld;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            bufQ      <= '0;
            olderIdx  <= 1'b0;
            rrPtr     <= 1'b0;
            RegWre    <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            bufQ     <= bufNext;
            olderIdx <= ageNext;
            if (grantVld) begin
                rrPtr     <= ~grantIdx;
                RegWre    <= |bufQ[grantIdx].regAddr;  // r0 is hardwired zero: consume without writing
                WriteReg  <= bufQ[grantIdx].regAddr;
                WriteData <= bufQ[grantIdx].data;
            end else begin
                RegWre <= 1'b0;
            end
        end
    end

`ifdef WB_FORWARD_EN
    // Later checks override earlier ones: output reg, then older buffer, then younger buffer.
    function automatic logic [DATA_W:0] fwdLookup(
        input logic [ADDR_W-1:0] addr,
        input wbEntry_t [1:0]    b,
        input logic              older,
        input logic              wre,
        input logic [ADDR_W-1:0] wreg,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W:0] res;
        res = '0;
        if (addr != '0) begin
            if (wre && wreg == addr)
                res = {1'b1, wdata};
            if (b[older].vld && b[older].regAddr == addr)
                res = {1'b1, b[older].data};
            if (b[~older].vld && b[~older].regAddr == addr)
                res = {1'b1, b[~older].data};
        end
        return res;
    endfunction

    assign {FwdHit1, FwdData1} = fwdLookup(FwdAddr1, bufQ, olderIdx, RegWre, WriteReg, WriteData);
    assign {FwdHit2, FwdData2} = fwdLookup(FwdAddr2, bufQ, olderIdx, RegWre, WriteReg, WriteData);
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: arrival-stamped buffer model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_regfile_wb_arbiter;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          Req0Valid, Req1Valid, Req0Ready, Req1Ready;
    logic [AW-1:0] Req0Reg, Req1Reg, WriteReg;
    logic [DW-1:0] Req0Data, Req1Data, WriteData;
    logic          RegWre, Busy;
`ifdef WB_FORWARD_EN
    logic [AW-1:0] FwdAddr1, FwdAddr2;
    logic          FwdHit1, FwdHit2;
    logic [DW-1:0] FwdData1, FwdData2;
`endif

    regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Reg(Req0Reg), .Req0Data(Req0Data),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Reg(Req1Reg), .Req1Data(Req1Data),
        .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
`ifdef WB_FORWARD_EN
        .FwdAddr1(FwdAddr1), .FwdAddr2(FwdAddr2), .FwdHit1(FwdHit1), .FwdHit2(FwdHit2),
        .FwdData1(FwdData1), .FwdData2(FwdData2),
`endif
        .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    int nCmp = 0, nFail = 0;
    bit checkOn = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each pending write carries an arrival stamp; output register is what was drained last.
    bit            mV[2]    = '{0, 0};
    logic [AW-1:0] mReg[2]  = '{0, 0};
    logic [DW-1:0] mData[2] = '{0, 0};
    int            mStamp[2] = '{0, 0};
    int            mRr = 0, cyc = 0;
    bit            oWre = 1'b0;
    logic [AW-1:0] oReg = '0;
    logic [DW-1:0] oData = '0;

    function automatic int grantOf();
        if (mV[0] && mV[1]) begin
            if (mReg[0] == mReg[1]) return (mStamp[0] < mStamp[1]) ? 0 : 1;
            return mRr;
        end
        if (mV[0]) return 0;
        if (mV[1]) return 1;
        return -1;
    endfunction

`ifdef WB_FORWARD_EN
    function automatic logic [DW:0] modelFwd(logic [AW-1:0] a);
        int best = -1;
        if (a == 0) return '0;
        for (int n = 0; n < 2; n++)
            if (mV[n] && mReg[n] == a && (best < 0 || mStamp[n] > mStamp[best])) best = n;
        if (best >= 0) return {1'b1, mData[best]};
        if (oWre && oReg == a) return {1'b1, oData};
        return '0;
    endfunction
`endif

    // Compare process: checks outputs mid-cycle, then advances the model across the next edge.
    initial begin
        int g;
        bit a0, a1;
        forever begin
            @(negedge CLK);
            if (checkOn) begin
                #2;
                g = grantOf();
                chk("Req0Ready", Req0Ready, !mV[0] || g == 0);
                chk("Req1Ready", Req1Ready, !mV[1] || g == 1);
                chk("Busy", Busy, mV[0] || mV[1]);
                chk("RegWre", RegWre, oWre);
                chk("WriteReg", WriteReg, oReg);
                chk("WriteData", WriteData, oData);
`ifdef WB_FORWARD_EN
                chk("Fwd1", {FwdHit1, FwdData1}, modelFwd(FwdAddr1));
                chk("Fwd2", {FwdHit2, FwdData2}, modelFwd(FwdAddr2));
`endif
                if (Reset) begin
                    mV = '{0, 0}; mRr = 0; oWre = 0; oReg = '0; oData = '0;
                end else begin
                    a0 = Req0Valid && (!mV[0] || g == 0);
                    a1 = Req1Valid && (!mV[1] || g == 1);
                    if (g >= 0) begin
                        oWre = (mReg[g] != 0); oReg = mReg[g]; oData = mData[g];
                        mV[g] = 0; mRr = 1 - g;
                    end else begin
                        oWre = 0;
                    end
                    if (a0) begin mV[0] = 1; mReg[0] = Req0Reg; mData[0] = Req0Data; mStamp[0] = 2 * cyc; end
                    if (a1) begin mV[1] = 1; mReg[1] = Req1Reg; mData[1] = Req1Data; mStamp[1] = 2 * cyc + 1; end
                end
                cyc++;
            end
        end
    end

    logic [AW+DW-1:0] wq[$];
    logic [AW-1:0]    fa1 = '0, fa2 = '0;

    task automatic cycle(bit v0, logic [AW-1:0] r0, logic [DW-1:0] d0,
                         bit v1, logic [AW-1:0] r1, logic [DW-1:0] d1, bit rst);
        @(negedge CLK);
        Req0Valid = v0; Req0Reg = r0; Req0Data = d0;
        Req1Valid = v1; Req1Reg = r1; Req1Data = d1;
        Reset = rst;
`ifdef WB_FORWARD_EN
        FwdAddr1 = fa1; FwdAddr2 = fa2;
`endif
        #3;
        if (RegWre === 1'b1) wq.push_back({WriteReg, WriteData});
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int k0, k1;
        Reset = 1'b1;
        Req0Valid = 0; Req0Reg = 0; Req0Data = 0;
        Req1Valid = 0; Req1Reg = 0; Req1Data = 0;
`ifdef WB_FORWARD_EN
        FwdAddr1 = 0; FwdAddr2 = 0;
`endif
        @(posedge CLK); #1;
        checkOn = 1'b1;

        // Reset state
        idle();
        chk("rst RegWre", RegWre, 0);
        chk("rst WriteReg", WriteReg, 0);
        chk("rst Busy", Busy, 0);
        chk("rst Ready0", Req0Ready, 1);
        chk("rst Ready1", Req1Ready, 1);

        // Reset mid-stream discards buffered writes
        wq.delete();
        cycle(1, 3, 16'h1111, 1, 4, 16'h2222, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("midrst full Busy", Busy, 1);
        repeat (4) begin
            idle();
            chk("midrst RegWre", RegWre, 0);
            chk("midrst Busy", Busy, 0);
            chk("midrst Readys", {Req0Ready, Req1Ready}, 2'b11);
        end
        chk("midrst no writes", wq.size(), 0);

        // Contention: both stream distinct registers, grants must alternate 0,1,0,1...
        wq.delete();
        k0 = 0; k1 = 0;
        repeat (8) begin
            cycle(1, AW'(1 + k0 % 6), DW'(16'h1000 + k0), 1, AW'(8 + k1 % 6), DW'(16'h2000 + k1), 0);
            if (Req0Ready === 1'b1) k0++;
            if (Req1Ready === 1'b1) k1++;
        end
        for (int i = 0; i < 10 && Busy !== 1'b0; i++) idle();
        chk("contention drained", Busy, 0);
        idle();
        chk("contention k0", k0, 5);
        chk("contention k1", k1, 4);
        chk("contention count", wq.size(), 9);
        for (int i = 0; i < wq.size() && i < 9; i++)
            chk("contention order", wq[i][DW-1:0], ((i % 2) ? 32'h2000 : 32'h1000) + i / 2);

        // Single write latency; leaves the RR pointer at 1
        cycle(1, 5, 16'hABCD, 0, 0, 0, 0);
        idle();
        idle();
        chk("single RegWre", RegWre, 1);
        chk("single WriteReg", WriteReg, 5);
        chk("single WriteData", WriteData, 16'hABCD);
        idle();
        chk("single RegWre off", RegWre, 0);

        // Same-register ordering beats the RR pointer
        wq.delete();
        cycle(1, 7, 16'h0001, 1, 7, 16'h0002, 0);
        repeat (4) idle();
        chk("samereg count", wq.size(), 2);
        chk("samereg first", wq.size() > 0 ? wq[0] : '1, {4'd7, 16'h0001});
        chk("samereg second", wq.size() > 1 ? wq[1] : '1, {4'd7, 16'h0002});

        // r0 write is accepted and silently dropped
        cycle(0, 0, 0, 1, 0, 16'hFFFF, 0);
        chk("r0 Ready1", Req1Ready, 1);
        idle();
        chk("r0 Busy pending", Busy, 1);
        chk("r0 RegWre a", RegWre, 0);
        idle();
        chk("r0 RegWre b", RegWre, 0);
        chk("r0 Busy clear", Busy, 0);

`ifdef WB_FORWARD_EN
        cycle(1, 9, 16'h0055, 0, 0, 0, 0);
        cycle(1, 9, 16'h00AA, 0, 0, 0, 0);
        fa1 = 9; fa2 = 0;
        idle();
        chk("fwd hit1", FwdHit1, 1);
        chk("fwd data1", FwdData1, 16'h00AA);
        chk("fwd hit2", FwdHit2, 0);
        repeat (3) idle();
`endif

        // Randomized traffic with frequent register collisions and rare resets
        repeat (600) begin
            fa1 = AW'($urandom_range(0, 3));
            fa2 = AW'($urandom_range(0, 15));
            cycle($urandom_range(0, 99) < 70,
                  AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15)),
                  DW'($urandom),
                  $urandom_range(0, 99) < 70,
                  AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15)),
                  DW'($urandom),
                  $urandom_range(0, 63) == 0);
        end
        repeat (4) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port arbiter and sequencer for the 16x16 register file.
- Two writeback requesters share the file's single write port: Req0 (ALU writeback) and Req1 (load writeback).
- Each requester has a one-entry holding buffer with valid/ready handshake.
- A round-robin scheduler drains one buffered write per cycle into registered RegWre/WriteReg/WriteData outputs, which feed the register file directly.

Parameters:
ADDR_W, 4, register address width (16 registers)
DATA_W, 16, register data width

Ports:
CLK  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Req0Valid  in  1  ALU write request
Req0Ready  out  1  ALU buffer can accept this cycle
Req0Reg  in  ADDR_W  ALU destination register
Req0Data  in  DATA_W  ALU result
Req1Valid  in  1  load write request
Req1Ready  out  1  load buffer can accept this cycle
Req1Reg  in  ADDR_W  load destination register
Req1Data  in  DATA_W  load data
RegWre  out  1  register file write enable (registered)
WriteReg  out  ADDR_W  register file write address (registered)
WriteData  out  DATA_W  register file write data (registered)
Busy  out  1  either holding buffer valid (combinational from state)

Behaviour:
- Reset, sampled at the CLK edge:
  - Both buffers invalid; RegWre=0, WriteReg=0, WriteData=0.
  - RR pointer = 0 (Req0 preferred); age flag = 0.
  - Reset wins over any simultaneous handshake. In-flight buffered writes are discarded and never reach the file.
- Buffer n holds Valid/Reg/Data. A handshake occurs when ReqnValid && ReqnReady at the edge, and loads the buffer.
- ReqnReady = !BufnValid || Grant==n this cycle. Grant depends only on buffer state, so there is no combinational loop. This allows one accept per requester per cycle.
- Grant selection (combinational, from buffers only):
  - Only one buffer valid -> grant it.
  - Both valid, different Reg -> grant the buffer the RR pointer selects.
  - Both valid, same Reg -> grant the older buffer (age flag) so the file ends with the younger value.
  - Neither valid -> no grant.
- Age flag: records which buffer was filled first. If both are filled on the same edge, buffer 0 is older. It is updated on every fill/drain.
- RR pointer: after granting n, the pointer moves to the other requester. It is unchanged when there is no grant.
- Output register, each edge:
  - With a grant: WriteReg/WriteData = granted entry; RegWre = (Reg != 0).
  - Register 0 writes are consumed silently with RegWre=0, because r0 is hardwired 0.
  - Without a grant: RegWre=0; WriteReg/WriteData hold their last value.
- Latency: accept at edge N -> output regs at edge N+1 -> register file updated at edge N+2 (minimum, uncontended).
- Contention: if both requesters stream continuously, grants alternate 0,1,0,1,... Each requester sustains 1 write per 2 cycles, and its Ready deasserts in cycles where its full buffer is not granted.
- Simultaneous drain and refill of the same buffer on the same edge is legal. The new entry becomes the younger one.

Optional Feature:
Macro WB_FORWARD_EN.
- Defined: adds inputs FwdAddr1/FwdAddr2 [ADDR_W] and outputs FwdHit1/FwdHit2 [1] and FwdData1/FwdData2 [DATA_W].
  - FwdHitk=1 when FwdAddrk != 0 and it matches a pending write: a valid buffer, or the output register with RegWre=1.
  - FwdDatak is the youngest matching value, in priority order: younger buffer, then older buffer, then output register.
  - Both outputs are combinational and are 0 when there is no hit.
- Undefined: these ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-stream: fill both buffers (r3=0x1111, r4=0x2222), assert Reset 1 cycle -> RegWre=0 for all following cycles; Busy=0; both Readys=1.
- Single write: Req0 r5=0xABCD at edge 0 -> edge 1 RegWre=1, WriteReg=5, WriteData=0xABCD; edge 2 RegWre=0.
- Contention: both requesters stream for 8 cycles with distinct regs -> output order 0,1,0,1,...; no request lost; each Ready low exactly in its non-granted full cycles.
- Same-register ordering: Req0 r7=0x0001 and Req1 r7=0x0002 on the same edge -> r7 written 0x0001 then 0x0002, even with the RR pointer at 1.
- r0 write: Req1 r0=0xFFFF -> accepted (Ready=1); RegWre stays 0; buffer clears.
- WB_FORWARD_EN: buffer r9=0x00AA pending with output reg r9=0x0055, FwdAddr1=9 -> FwdHit1=1, FwdData1=0x00AA; FwdAddr2=0 -> FwdHit2=0.
